// File: rtl/code_lock_param_if.sv
// Keypad-side bundle for code_lock_param: strobed digit/command inputs and
// actuator/status outputs. The keypad decoder is the master, the lock the slave.
interface code_lock_param_if #(
    parameter int DW = 4,
    parameter int FW = 2
);
    logic          digit_valid;
    logic [DW-1:0] digit;
    logic          set_req;
    logic          cancel;
    logic          unlocked;
    logic          locked_out;
    logic          bad_code;
    logic          code_changed;
    logic          prog_err;
    logic [FW-1:0] fail_cnt;
    logic [2:0]    state_o;

    modport master (
        output digit_valid, digit, set_req, cancel,
        input  unlocked, locked_out, bad_code, code_changed, prog_err, fail_cnt, state_o
    );

    modport slave (
        input  digit_valid, digit, set_req, cancel,
        output unlocked, locked_out, bad_code, code_changed, prog_err, fail_cnt, state_o
    );
endinterface

// File: rtl/code_lock_param.sv
// Parametrised electronic code lock: whole-code evaluation, brute-force lockout,
// inter-key entry timeout and two-pass confirmed passcode change.
module code_lock_param #(
    parameter int DIGITS         = 4,
    parameter int DW             = 4,
    parameter int MAX_FAIL       = 3,
    parameter int UNLOCK_CYCLES  = 5,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int ENTRY_TIMEOUT  = 64,
    parameter logic [DIGITS*DW-1:0] DEFAULT_CODE = 16'h4321
) (
    input  logic               clk,
    input  logic               rst,
    code_lock_param_if.slave   bus
);
    localparam int IW     = $clog2(DIGITS);
    localparam int FW     = $clog2(MAX_FAIL + 1);
    localparam int TMAX_A = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMAX   = (TMAX_A > ENTRY_TIMEOUT) ? TMAX_A : ENTRY_TIMEOUT;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
    localparam logic [TW-1:0] UNL_LAST  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] ENT_LAST  = TW'(ENTRY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTER    = 3'd1,
        S_UNLOCKED = 3'd2,
        S_PROG1    = 3'd3,
        S_PROG2    = 3'd4,
        S_LOCKOUT  = 3'd5
    } state_t;

    state_t               state_q;
    logic [DIGITS*DW-1:0] code_q;
    logic [DIGITS*DW-1:0] shadow_q;
    logic [IW-1:0]        idx_q;
    logic                 mismatch_q;
    logic [FW-1:0]        fail_cnt_q;
    logic [TW-1:0]        timer_q;
    logic                 unlocked_q;
    logic                 locked_out_q;
    logic                 bad_code_q;
    logic                 code_changed_q;
    logic                 prog_err_q;

    logic take;
    logic code_miss;
    logic shadow_miss;
    logic idle_expired;

    // A digit counts only when no higher-priority command shares its cycle.
    assign take         = bus.digit_valid & ~bus.cancel & ~bus.set_req;
    assign code_miss    = (bus.digit != code_q[idx_q*DW +: DW]);
    assign shadow_miss  = (bus.digit != shadow_q[idx_q*DW +: DW]);
    assign idle_expired = (timer_q == ENT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            code_q         <= DEFAULT_CODE;
            shadow_q       <= '0;
            idx_q          <= '0;
            mismatch_q     <= 1'b0;
            fail_cnt_q     <= '0;
            timer_q        <= '0;
            unlocked_q     <= 1'b0;
            locked_out_q   <= 1'b0;
            bad_code_q     <= 1'b0;
            code_changed_q <= 1'b0;
            prog_err_q     <= 1'b0;
        end else begin
            unlocked_q     <= 1'b0;
            locked_out_q   <= 1'b0;
            bad_code_q     <= 1'b0;
            code_changed_q <= 1'b0;
            prog_err_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    idx_q      <= '0;
                    mismatch_q <= 1'b0;
                    timer_q    <= '0;
                    if (take) begin
                        mismatch_q <= (bus.digit != code_q[DW-1:0]);
                        idx_q      <= IW'(1);
                        state_q    <= S_ENTER;
                    end
                end

                S_ENTER: begin
                    if (bus.cancel) begin
                        state_q <= S_IDLE;
                    end else if (take) begin
                        timer_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            if (!(mismatch_q || code_miss)) begin
                                state_q    <= S_UNLOCKED;
                                unlocked_q <= 1'b1;
                                fail_cnt_q <= '0;
                            end else begin
                                bad_code_q <= 1'b1;
                                if (fail_cnt_q == FAIL_LAST) begin
                                    fail_cnt_q   <= '0;
                                    state_q      <= S_LOCKOUT;
                                    locked_out_q <= 1'b1;
                                end else begin
                                    fail_cnt_q <= fail_cnt_q + 1'b1;
                                    state_q    <= S_IDLE;
                                end
                            end
                        end else begin
                            mismatch_q <= mismatch_q | code_miss;
                            idx_q      <= idx_q + 1'b1;
                        end
                    end else if (idle_expired) begin
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_UNLOCKED: begin
                    if (bus.cancel) begin
                        state_q <= S_IDLE;
                    end else if (bus.set_req) begin
                        state_q <= S_PROG1;
                        idx_q   <= '0;
                        timer_q <= '0;
                    end else if (timer_q == UNL_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        timer_q    <= timer_q + 1'b1;
                        unlocked_q <= 1'b1;
                    end
                end

                S_PROG1: begin
                    if (bus.cancel) begin
                        state_q <= S_IDLE;
                    end else if (take) begin
                        timer_q                   <= '0;
                        shadow_q[idx_q*DW +: DW]  <= bus.digit;
                        if (idx_q == LAST_IDX) begin
                            state_q    <= S_PROG2;
                            idx_q      <= '0;
                            mismatch_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (idle_expired) begin
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_PROG2: begin
                    if (bus.cancel) begin
                        state_q <= S_IDLE;
                    end else if (take) begin
                        timer_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_IDLE;
                            if (!(mismatch_q || shadow_miss)) begin
                                code_q         <= shadow_q;
                                code_changed_q <= 1'b1;
                            end else begin
                                prog_err_q <= 1'b1;
                            end
                        end else begin
                            mismatch_q <= mismatch_q | shadow_miss;
                            idx_q      <= idx_q + 1'b1;
                        end
                    end else if (idle_expired) begin
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_LOCKOUT: begin
                    if (timer_q == LCK_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        timer_q      <= timer_q + 1'b1;
                        locked_out_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.unlocked     = unlocked_q;
    assign bus.locked_out   = locked_out_q;
    assign bus.bad_code     = bad_code_q;
    assign bus.code_changed = code_changed_q;
    assign bus.prog_err     = prog_err_q;
    assign bus.fail_cnt     = fail_cnt_q;
    assign bus.state_o      = state_q;
endmodule
